// File: rtl/sock_dec_pkg.sv
// Shared definitions for the socket command-line decoder.
//   dec_state_e : parser states
//   Err*        : error codes reported on err_code
//   Ch*         : ASCII constants used by the grammar
//   hex_nibble  : classifies a byte as a hex digit and returns its value
package sock_dec_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSp1,
        StAddr,
        StData,
        StEmit,
        StSkip
    } dec_state_e;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrBadChar  = 2'd1;
    localparam logic [1:0] ErrOverflow = 2'd2;
    localparam logic [1:0] ErrMissing  = 2'd3;

    localparam logic [7:0] ChLf = 8'h0A;
    localparam logic [7:0] ChCr = 8'h0D;
    localparam logic [7:0] ChSp = 8'h20;
    localparam logic [7:0] ChW  = 8'h57;
    localparam logic [7:0] ChR  = 8'h52;

    // Returns {is_hex, nibble}. Letters a-f / A-F have low nibbles 1..6,
    // so adding 9 yields 10..15 without a full subtraction.
    function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
        logic [4:0] res;
        res = 5'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, ch[3:0]};
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            res = {1'b1, ch[3:0] + 4'd9};
        end
        return res;
    endfunction

endpackage

// File: rtl/sock_hex_accum.sv
// Hex digit shift accumulator shared by the address and data fields.
//   clock, reset : clock and async active-high reset
//   clear        : start a new field (priority over shift)
//   shift        : append nibble as the new least-significant digit
//   nibble       : digit value
//   limit        : maximum digit count for the current field
//   value        : accumulated, zero-extended field value
//   count        : digits accumulated so far
//   full         : count has reached limit; another digit would overflow
module sock_hex_accum #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          shift,
    input  logic [3:0]    nibble,
    input  logic [CW-1:0] limit,
    output logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W+3:0] shifted;

    assign shifted = {value, nibble};
    assign full    = (count >= limit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (shift && !full) begin
            value <= shifted[W-1:0];
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sock_line_decoder.sv
// Parses LF-terminated ASCII command lines ("W addr data" / "R addr") into
// read/write commands. Malformed lines raise a one-cycle error pulse and are
// discarded up to the next LF.
//   clock, reset         : clock and async active-high reset
//   in_data/valid/ready  : byte stream input
//   cmd_valid/ready      : decoded command handshake
//   cmd_write/addr/data  : command fields (data is 0 for reads)
//   err_valid/err_code   : error pulse, 1 bad char, 2 overflow, 3 missing field
// Optional build macro SOCK_DEC_STATS_EN adds saturating counters
//   stat_cmds (command handshakes) and stat_errs (errors).
module sock_line_decoder
    import sock_dec_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic              err_valid,
    output logic [1:0]        err_code
`ifdef SOCK_DEC_STATS_EN
    ,
    output logic [15:0]       stat_cmds,
    output logic [15:0]       stat_errs
`endif
);

    localparam int unsigned AccW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CntW = $clog2(AccW / 4 + 1);

    dec_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              accept;
    logic              is_hex, is_lf, is_cr, is_sp;
    logic [3:0]        nibble;
    logic              raise;
    logic [1:0]        raise_code;

    logic              acc_clear, acc_shift, acc_full;
    logic [AccW-1:0]   acc_value;
    logic [CntW-1:0]   acc_count, acc_limit;

    assign in_ready         = !reset && (state_q != StEmit);
    assign accept           = in_valid && in_ready;
    assign {is_hex, nibble} = hex_nibble(in_data);
    assign is_lf            = (in_data == ChLf);
    assign is_cr            = (in_data == ChCr);
    assign is_sp            = (in_data == ChSp);
    assign acc_limit        = (state_q == StData) ? CntW'(DATA_W / 4) : CntW'(ADDR_W / 4);

    sock_hex_accum #(
        .W  (AccW),
        .CW (CntW)
    ) u_accum (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clear),
        .shift  (acc_shift),
        .nibble (nibble),
        .limit  (acc_limit),
        .value  (acc_value),
        .count  (acc_count),
        .full   (acc_full)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        acc_clear   = 1'b0;
        acc_shift   = 1'b0;
        raise       = 1'b0;
        raise_code  = ErrNone;

        if (state_q == StEmit) begin
            if (cmd_ready) begin
                cmd_valid_d = 1'b0;
                state_d     = StIdle;
            end
        end else if (accept && !is_cr) begin
            case (state_q)
                StIdle: begin
                    if (in_data == ChW || in_data == ChR) begin
                        write_d   = (in_data == ChW);
                        acc_clear = 1'b1;
                        state_d   = StSp1;
                    end else if (!is_lf) begin
                        raise      = 1'b1;
                        raise_code = ErrBadChar;
                    end
                end
                StSp1: begin
                    if (is_sp) begin
                        state_d = StAddr;
                    end else begin
                        raise      = 1'b1;
                        raise_code = is_lf ? ErrMissing : ErrBadChar;
                    end
                end
                StAddr: begin
                    if (is_hex) begin
                        if (acc_full) begin
                            raise      = 1'b1;
                            raise_code = ErrOverflow;
                        end else begin
                            acc_shift = 1'b1;
                        end
                    end else if (is_sp || is_lf) begin
                        if (acc_count == '0) begin
                            raise      = 1'b1;
                            raise_code = ErrMissing;
                        end else if (is_sp && write_q) begin
                            // Latch the address so the accumulator can be reused for data.
                            addr_d    = acc_value[ADDR_W-1:0];
                            acc_clear = 1'b1;
                            state_d   = StData;
                        end else if (is_lf && !write_q) begin
                            cmd_valid_d = 1'b1;
                            cmd_write_d = 1'b0;
                            cmd_addr_d  = acc_value[ADDR_W-1:0];
                            cmd_data_d  = '0;
                            state_d     = StEmit;
                        end else begin
                            raise      = 1'b1;
                            raise_code = is_sp ? ErrBadChar : ErrMissing;
                        end
                    end else begin
                        raise      = 1'b1;
                        raise_code = ErrBadChar;
                    end
                end
                StData: begin
                    if (is_hex) begin
                        if (acc_full) begin
                            raise      = 1'b1;
                            raise_code = ErrOverflow;
                        end else begin
                            acc_shift = 1'b1;
                        end
                    end else if (is_lf) begin
                        if (acc_count == '0) begin
                            raise      = 1'b1;
                            raise_code = ErrMissing;
                        end else begin
                            cmd_valid_d = 1'b1;
                            cmd_write_d = 1'b1;
                            cmd_addr_d  = addr_q;
                            cmd_data_d  = acc_value[DATA_W-1:0];
                            state_d     = StEmit;
                        end
                    end else begin
                        raise      = 1'b1;
                        raise_code = ErrBadChar;
                    end
                end
                StSkip: begin
                    if (is_lf) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (raise) begin
            err_valid_d = 1'b1;
            err_code_d  = raise_code;
            // An LF already ended the offending line, so nothing is left to skip.
            state_d     = is_lf ? StIdle : StSkip;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            addr_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ErrNone;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

`ifdef SOCK_DEC_STATS_EN
    logic [15:0] stat_cmds_q, stat_errs_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_cmds_q <= '0;
            stat_errs_q <= '0;
        end else begin
            if (cmd_valid_q && cmd_ready && stat_cmds_q != 16'hFFFF) begin
                stat_cmds_q <= stat_cmds_q + 16'd1;
            end
            if (err_valid_d && stat_errs_q != 16'hFFFF) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
        end
    end

    assign stat_cmds = stat_cmds_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_sock_line_decoder.sv
// Directed bench for sock_line_decoder with hand-computed expectations.
module tb_sock_line_decoder;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              err_valid;
    logic [1:0]        err_code;
`ifdef SOCK_DEC_STATS_EN
    logic [15:0]       stat_cmds;
    logic [15:0]       stat_errs;
`endif

    sock_line_decoder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .err_valid (err_valid),
        .err_code  (err_code)
`ifdef SOCK_DEC_STATS_EN
        ,
        .stat_cmds (stat_cmds),
        .stat_errs (stat_errs)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int cmd_seen = 0;

    // Each output register holds for a whole cycle, so the falling edge sees a pulse once.
    always @(negedge clock) begin
        if (err_valid) err_seen++;
        if (cmd_valid && cmd_ready) cmd_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Returns 1 time unit after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outputs", {63'd0, cmd_valid | cmd_write | err_valid | (|cmd_addr)
              | (|cmd_data) | (|err_code)}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Write command, LF-to-valid latency of one cycle.
        send_str("W 1A 0000BEEF");
        send_byte(LF);
        check("w1_valid", {63'd0, cmd_valid}, 64'd1);
        check("w1_write", {63'd0, cmd_write}, 64'd1);
        check("w1_addr", {48'd0, cmd_addr}, 64'h001A);
        check("w1_data", {32'd0, cmd_data}, 64'h0000BEEF);

        // Read with CR before LF.
        send_str("R ff");
        send_byte(CR);
        send_byte(LF);
        check("r1_valid", {63'd0, cmd_valid}, 64'd1);
        check("r1_fields", {cmd_write, 15'd0, cmd_addr, cmd_data}, {16'd0, 16'h00FF, 32'd0});
        check("r1_no_err", 64'(err_seen), 64'd0);

        // Address overflow on the fifth digit.
        send_str("W 1234");
        send_byte("5");
        check("ovf_pulse", {61'd0, err_valid, err_code}, {61'd0, 1'b1, 2'd2});
        send_str(" 1");
        send_byte(LF);
        check("ovf_no_cmd", {63'd0, cmd_valid}, 64'd0);
        check("ovf_one_pulse", 64'(err_seen), 64'd1);
        send_str("R 1");
        send_byte(LF);
        check("r2_fields", {cmd_valid, cmd_write, 14'd0, cmd_addr}, {1'b1, 1'b0, 14'd0, 16'h0001});

        // Bad leading char, missing address, empty line.
        send_byte("X");
        check("bad_char", {61'd0, err_valid, err_code}, {61'd0, 1'b1, 2'd1});
        send_str(" 1");
        send_byte(LF);
        check("bad_skip_no_cmd", {63'd0, cmd_valid}, 64'd0);
        send_byte("R");
        send_byte(LF);
        check("missing_addr", {61'd0, err_valid, err_code}, {61'd0, 1'b1, 2'd3});
        send_byte(LF);
        check("empty_line", {62'd0, err_valid, cmd_valid}, 64'd0);
        check("err_total", 64'(err_seen), 64'd3);

        // Back-pressure: command held stable, input stalled.
        @(negedge clock);
        cmd_ready = 1'b0;
        send_str("W 4 5");
        send_byte(LF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_stable", {13'd0, cmd_valid, cmd_write, cmd_addr, cmd_data, in_ready},
                  {13'd0, 1'b1, 1'b1, 16'h0004, 32'h00000005, 1'b0});
        end
        cmd_ready = 1'b1;
        in_data   = "R";
        in_valid  = 1'b1;
        check("bp_hs_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clock);
        check("bp_after_hs", {62'd0, cmd_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        send_str(" 7");
        send_byte(LF);
        check("r3_fields", {cmd_valid, cmd_write, 14'd0, cmd_addr}, {1'b1, 1'b0, 14'd0, 16'h0007});

        // Reset mid-line.
        send_str("W 12");
        check("cmd_total", 64'(cmd_seen), 64'd5);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {cmd_valid, cmd_write, 4'd0, cmd_addr, cmd_data, err_valid,
              err_code, in_ready, 7'd0}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        send_str("R 3");
        send_byte(LF);
        check("r4_fields", {cmd_valid, cmd_write, 14'd0, cmd_addr}, {1'b1, 1'b0, 14'd0, 16'h0003});
        @(negedge clock);
`ifdef SOCK_DEC_STATS_EN
        check("stat_cmds", {48'd0, stat_cmds}, 64'd1);
        check("stat_errs", {48'd0, stat_errs}, 64'd0);
`endif
        check("final_err_total", 64'(err_seen), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
